// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding, default operand width and the step-counter width rule.
package serial_addsub_pkg;

    // Default operand/result width used by the top and the interface.
    localparam int DEF_WIDTH = 8;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step counter width. The extra bit keeps the terminal-count compare
    // exact, with no wrap-around, even when WIDTH is a power of two.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle between a requester (master) and the bit-serial
// adder/subtractor (slave).
interface serial_addsub_if
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    // Request side.
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // Status and result side.
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow
    );

endinterface

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder. This is the only arithmetic cell in the serial
// datapath; it is reused once per clock for each bit position.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial, LSB-first adder/subtractor. One full-adder cell plus a carry
// flip-flop process one bit per clock; a three-state controller loads the
// operands, steps WIDTH times and pulses done for one cycle.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    serial_addsub_if.slave  bus
);

    localparam int                CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    // Partial sum: holds the WIDTH-1 low result bits once the LSB has
    // been shifted all the way down; the MSB comes straight from the cell.
    logic [WIDTH-2:0]   r_acc;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;

    logic               w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_acc_full;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_last;

    // Subtraction is a + ~b + 1: B is inverted at load and the +1 enters
    // through the initial carry.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
            assign w_b_eff[gi] = bus.b[gi] ^ bus.sub;
        end
    endgenerate

    fa_cell u_fa_cell (
        .i_a    (r_op_a[0]),
        .i_b    (r_op_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_carry)
    );

    // New sum bit enters at the top; older bits move toward the LSB.
    assign w_acc_full = {w_sum, r_acc};
    assign w_last     = (r_cnt == LAST_STEP);

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;

    // Controller, operand shifters, carry flip-flop and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_op_a  <= bus.a;
                        r_op_b  <= w_b_eff;
                        r_carry <= bus.sub;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_acc   <= w_acc_full[WIDTH-1:1];
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // MSB step: the carry entering this step is the
                        // carry into the sign bit, so overflow is their XOR.
                        r_result <= w_acc_full;
                        r_cout   <= w_carry;
                        r_ovf    <= r_carry ^ w_carry;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed cases with
// literal expectations, then a randomized sweep, all cross-checked every
// cycle against an arithmetic/timing reference model.
module tb_serial_addsub;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference arithmetic from plain integer math.
    function automatic void ref_op(input int a, input int b, input bit s,
                                   output int res, output bit co, output bit ov);
        int m, sa, sb, sr;
        m  = 1 << W;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (!s) begin
            res = (a + b) % m;
            co  = (a + b) >= m;
            sr  = sa + sb;
        end else begin
            res = (a - b + m) % m;
            co  = (a >= b);
            sr  = sa - sb;
        end
        ov = (sr > m / 2 - 1) || (sr < -(m / 2));
    endfunction

    // Timing/result model: an accepted start at edge E0 makes busy true for
    // edges E0..E0+W-1, done true after E0+W, and the next start may be
    // accepted from edge E0+W+2 on.
    int edge_cnt  = 0;
    int load_edge = 0;
    bit active    = 1'b0;
    int pend_res  = 0;
    bit pend_co   = 1'b0;
    bit pend_ov   = 1'b0;
    int exp_res   = 0;
    bit exp_co    = 1'b0;
    bit exp_ov    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active  = 1'b0;
            exp_res = 0;
            exp_co  = 1'b0;
            exp_ov  = 1'b0;
        end else begin
            edge_cnt++;
            if (active && (edge_cnt - load_edge == W)) begin
                exp_res = pend_res;
                exp_co  = pend_co;
                exp_ov  = pend_ov;
            end
            if (bus.start && (!active || (edge_cnt - load_edge >= W + 2))) begin
                active    = 1'b1;
                load_edge = edge_cnt;
                ref_op(int'(bus.a), int'(bus.b), bus.sub, pend_res, pend_co, pend_ov);
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model.
    always @(negedge clk) begin : cmp
        int k;
        bit eb, ed;
        k  = edge_cnt - load_edge;
        eb = active && (k >= 0) && (k <= W - 1);
        ed = active && (k == W);
        chk("cyc_busy",     int'(bus.busy),     int'(eb));
        chk("cyc_done",     int'(bus.done),     int'(ed));
        chk("cyc_result",   int'(bus.result),   exp_res);
        chk("cyc_cout",     int'(bus.cout),     int'(exp_co));
        chk("cyc_overflow", int'(bus.overflow), int'(exp_ov));
    end

    // Launch one operation and wait (bounded) for done.
    // mode 0: plain, 1: scramble inputs during RUN, 2: extra starts in RUN and DONE.
    task automatic run_op(input int a, input int b, input bit s, input int mode,
                          output int res, output bit co, output bit ov,
                          output int lat, output int busy_n);
        bit got;
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.sub   = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat    = 0;
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 3 * W && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            got = bus.done;
            if (!got && mode == 1) begin
                bus.a   = W'($urandom_range(0, 255));
                bus.b   = W'($urandom_range(0, 255));
                bus.sub = 1'($urandom_range(0, 1));
            end
            if (mode == 2 && lat == 3) begin
                bus.a = W'(1); bus.b = W'(1); bus.sub = 1'b0; bus.start = 1'b1;
            end
            if (mode == 2 && lat == 4) bus.start = 1'b0;
        end
        if (!got) chk("done_timeout", 0, 1);
        res = int'(bus.result);
        co  = bus.cout;
        ov  = bus.overflow;
        if (mode == 2) begin
            bus.a = W'(1); bus.b = W'(1); bus.start = 1'b1;
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Directed case: pin the model against literals, then the DUT.
    task automatic chk_op(input string nm, input int a, input int b, input bit s,
                          input int er, input bit ec, input bit eo);
        int mr, r, lat, bn;
        bit mc, mo, c, o;
        ref_op(a, b, s, mr, mc, mo);
        chk({nm, "_model_res"}, mr, er);
        chk({nm, "_model_cout"}, int'(mc), int'(ec));
        chk({nm, "_model_ovf"}, int'(mo), int'(eo));
        run_op(a, b, s, 0, r, c, o, lat, bn);
        chk({nm, "_result"}, r, er);
        chk({nm, "_cout"}, int'(c), int'(ec));
        chk({nm, "_ovf"}, int'(o), int'(eo));
        $display("op %s: a=%0d b=%0d sub=%0d -> result=%0d cout=%0d ovf=%0d", nm, a, b, s, r, c, o);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, lat, bn, dn, mr;
        bit c, o, mc, mo;

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_cout", int'(bus.cout), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        @(posedge clk);
        #1;

        // Basic add with latency and busy length.
        run_op(100, 27, 1'b0, 0, r, c, o, lat, bn);
        chk("t1_result", r, 127);
        chk("t1_cout", int'(c), 0);
        chk("t1_ovf", int'(o), 0);
        chk("t1_latency", lat, W + 1);
        chk("t1_busy_cycles", bn, W);
        $display("op t1: 100+27 -> result=%0d latency=%0d busy=%0d", r, lat, bn);

        // Carry/overflow adds and subtracts.
        chk_op("add_200_100", 200, 100, 1'b0, 44, 1'b1, 1'b0);
        chk_op("add_127_1", 127, 1, 1'b0, 128, 1'b0, 1'b1);
        chk_op("add_255_1", 255, 1, 1'b0, 0, 1'b1, 1'b0);
        chk_op("sub_5_3", 5, 3, 1'b1, 2, 1'b1, 1'b0);
        chk_op("sub_3_5", 3, 5, 1'b1, 254, 1'b0, 1'b0);
        chk_op("sub_128_1", 128, 1, 1'b1, 127, 1'b1, 1'b1);
        chk_op("sub_0_0", 0, 0, 1'b1, 0, 1'b1, 1'b0);

        // Starts during RUN and in the DONE cycle are ignored.
        run_op(100, 27, 1'b0, 2, r, c, o, lat, bn);
        chk("t4_result", r, 127);
        chk("t4_latency", lat, W + 1);
        dn = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("t4_extra_done", dn, 0);
        $display("op t4: 100+27 with ignored starts -> result=%0d extra_done=%0d", r, dn);
        @(posedge clk);
        #1;

        // Inputs scrambled during RUN do not affect the operation.
        run_op(77, 200, 1'b1, 1, r, c, o, lat, bn);
        ref_op(77, 200, 1'b1, mr, mc, mo);
        chk("t5_result", r, 133);
        chk("t5_cout", int'(c), 0);
        chk("t5_ovf", int'(o), int'(mo));
        $display("op t5: 77-200 with scrambled inputs -> result=%0d cout=%0d", r, c);

        // Reset mid-RUN aborts; outputs clear immediately.
        bus.a = W'(55); bus.b = W'(66); bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_done", int'(bus.done), 0);
        chk("t6_result", int'(bus.result), 0);
        chk("t6_cout", int'(bus.cout), 0);
        chk("t6_ovf", int'(bus.overflow), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("t6_no_done", dn, 0);
        $display("op t6: reset mid-run -> done pulses afterwards=%0d", dn);
        @(posedge clk);
        #1;
        chk_op("t6_fresh", 10, 20, 1'b0, 30, 1'b0, 1'b0);

        // Random sweep.
        for (int n = 0; n < 500; n++) begin
            int ra, rb;
            bit rs;
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            ref_op(ra, rb, rs, mr, mc, mo);
            run_op(ra, rb, rs, 0, r, c, o, lat, bn);
            chk("rnd_result", r, mr);
            chk("rnd_cout", int'(c), int'(mc));
            chk("rnd_ovf", int'(o), int'(mo));
            chk("rnd_latency", lat, W + 1);
            $display("op rnd%0d: a=%0d b=%0d sub=%0d -> result=%0d cout=%0d ovf=%0d", n, ra, rb, rs, r, c, o);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
